mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits between the Ibex core's instruction and data OBI-style ports and a single-port RAM model.
- Arbitrates the two requesters onto one memory port, allowing one outstanding transaction at a time.
- Routes each response back to the port that issued it.
- Returns an error response for out-of-range addresses, and for memory responses that do not arrive within a timeout.

Parameters:
MEM_SIZE, 65536, RAM size in bytes; must be a power of 2.
MEM_START, 32'h00000000, RAM base address; must be aligned to MEM_SIZE.
TIMEOUT, 16, maximum cycles to wait for mem_rvalid after a grant before an error response is returned; must be ≥ 2.

Ports:
clk_sys  in  1  system clock
rst_sys  in  1  asynchronous active-high reset
instr_req  in  1  instruction fetch request
instr_addr  in  32  fetch address
instr_gnt  out  1  fetch request accepted
instr_rvalid  out  1  fetch response valid
instr_rdata  out  32  fetch read data
instr_err  out  1  fetch error (qualified by instr_rvalid)
data_req  in  1  data request
data_we  in  1  1 = write
data_be  in  4  byte enables
data_addr  in  32  data address
data_wdata  in  32  write data
data_gnt  out  1  data request accepted
data_rvalid  out  1  data response valid (reads and writes)
data_rdata  out  32  data read data
data_err  out  1  data error (qualified by data_rvalid)
mem_req  out  1  RAM request
mem_addr  out  32  RAM address
mem_write  out  1  RAM write enable
mem_be  out  4  RAM byte enables
mem_wdata  out  32  RAM write data
mem_rvalid  in  1  RAM response valid
mem_rdata  in  32  RAM read data

Behaviour:
- Clock is clk_sys; reset is rst_sys, asynchronous and active-high.
- State machine states: IDLE, WAIT_MEM, ERR_RESP. Registered signals:
  - owner: INSTR or DATA
  - tmo_cnt: $clog2(TIMEOUT+1) bits
  - last_owner: used only with round-robin arbitration
- Reset: state = IDLE, owner = INSTR, last_owner = DATA, tmo_cnt = 0.
  - While rst_sys is high, every output is 0 regardless of inputs.
- An in-flight transaction is dropped on reset; no response is ever issued for it.
- A grant is possible ("accept") when state = IDLE, or when state = WAIT_MEM and mem_rvalid = 1 (back-to-back issue).
- Winner selection:
  - Fixed priority: instr beats data.
  - Round-robin: see Optional Feature.
- On accept with the winner's address in range, i.e. (addr & ~(MEM_SIZE-1)) == MEM_START:
  - Combinationally drive mem_req = 1 and mem_addr = winner's address.
  - For a data winner also drive mem_write = data_we, mem_be = data_be, mem_wdata = data_wdata. For an instr winner these are 0.
  - Assert the winner's gnt in the same cycle.
  - Next state WAIT_MEM; owner <= winner; tmo_cnt <= 0.
- On accept with the winner's address out of range:
  - Assert gnt; mem_req stays 0.
  - Next state ERR_RESP; owner <= winner.
- Only the winner sees gnt; the loser's req stays pending; no gnt without req.
- When no accept occurs, all mem_* outputs are 0.
- WAIT_MEM:
  - mem_rvalid = 1: combinationally assert the owner's rvalid, with rdata = mem_rdata and err = 0.
    - Next state is WAIT_MEM if a new accept occurs in the same cycle, otherwise IDLE.
  - mem_rvalid = 0: tmo_cnt increments.
    - When tmo_cnt reaches TIMEOUT-1, next state is ERR_RESP. The last waiting cycle is the TIMEOUT-th; no grants occur in that cycle or in ERR_RESP.
- ERR_RESP (one cycle):
  - Assert the owner's rvalid with err = 1 and rdata = 0.
  - Next state IDLE; no grant in this cycle.
- A mem_rvalid arriving in IDLE or ERR_RESP (late or spurious) is ignored; no rvalid is forwarded.
- Non-owner rvalid, rdata and err are always 0.
- Latency with a 1-cycle RAM:
  - gnt in cycle N, rvalid in cycle N+1.
  - Sustained throughput is 1 transaction per cycle.
- Simultaneous instr_req and data_req in IDLE:
  - Fixed priority: instr is granted; data is granted at the earliest subsequent accept.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. When both requesters are pending, the one that is not last_owner wins.
  - last_owner <= winner on every accept.
  - A single pending requester always wins.
- Undefined:
  - Fixed instr priority.
  - last_owner is not implemented.
  - A continuous instr_req may starve data; this is accepted for the fixed-priority build.

Test Plan:
- Reset asserted mid-WAIT_MEM, then mem_rvalid = 1 while rst_sys is high -> all outputs 0; after release, state is IDLE and no stale rvalid appears.
- instr_req with instr_addr = 0x100, 1-cycle RAM returning 0xDEADBEEF -> instr_gnt in cycle N, instr_rvalid with rdata 0xDEADBEEF and err = 0 in cycle N+1.
- data write to 0x20, be = 4'b0011, wdata = 0x1234ABCD -> mem_write = 1, mem_be = 0011, mem_wdata = 0x1234ABCD; data_rvalid = 1 with err = 0 next cycle.
- data read at 0x00010000 with MEM_SIZE = 65536 -> data_gnt = 1, mem_req = 0; next cycle data_rvalid = 1, data_err = 1, rdata = 0.
- RAM never responds, TIMEOUT = 16 -> owner's rvalid with err = 1 exactly 17 cycles after gnt (the ERR_RESP cycle); a mem_rvalid arriving afterwards is ignored.
- Both requests held for 4 accepts -> without MEM_ARB_RR_EN: I, I, I, I; with MEM_ARB_RR_EN: I, D, I, D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//   Arbitrates the Ibex instruction and data OBI-style ports onto a single
//   single-port RAM interface with at most one outstanding transaction.
//   Responses are routed back to the issuing port. Out-of-range addresses
//   and RAM responses that miss the TIMEOUT window return an error response.
//
// Parameters:
//   MEM_SIZE  RAM size in bytes (power of 2)
//   MEM_START RAM base address (aligned to MEM_SIZE)
//   TIMEOUT   cycles to wait for mem_rvalid after a grant (>= 2)
//
// Ports:
//   clk_sys, rst_sys              clock, asynchronous active-high reset
//   instr_req/addr -> gnt/rvalid/rdata/err   instruction fetch port
//   data_req/we/be/addr/wdata -> gnt/rvalid/rdata/err   data port
//   mem_req/addr/write/be/wdata, mem_rvalid/rdata   RAM port
//
// Build option:
//   MEM_ARB_RR_EN  defined: round-robin arbitration between the two ports;
//                  undefined: fixed priority, instruction port wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_SIZE  = 65536,
  parameter logic [31:0] MEM_START = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_ERR_RESP = 2'd2;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       ADDR_MASK = ~(MEM_SIZE - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic        accept, grant, win, in_range;
  logic        resp_v, resp_err;
  logic [31:0] win_addr, resp_rdata;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
`endif

  // A new grant is possible when idle, or when the outstanding response
  // completes this cycle (back-to-back issue).
  assign accept = (state_q == ST_IDLE) || ((state_q == ST_WAIT_MEM) && mem_rvalid);
  assign grant  = accept && (instr_req || data_req);

`ifdef MEM_ARB_RR_EN
  // On contention the port not served last wins; a lone requester always wins.
  assign win = (instr_req && data_req) ? ~last_owner_q
                                       : (data_req ? OWN_DATA : OWN_INSTR);
`else
  assign win = instr_req ? OWN_INSTR : OWN_DATA;
`endif

  assign win_addr = (win == OWN_DATA) ? data_addr : instr_addr;
  assign in_range = (win_addr & ADDR_MASK) == MEM_START;

  // ERR_RESP covers both out-of-range requests and timeouts.
  assign resp_err   = (state_q == ST_ERR_RESP);
  assign resp_v     = ((state_q == ST_WAIT_MEM) && mem_rvalid) || resp_err;
  assign resp_rdata = resp_err ? '0 : mem_rdata;

  // Outputs are forced low while reset is held, independent of inputs.
  always_comb begin
    instr_gnt    = 1'b0;
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    instr_err    = 1'b0;
    data_gnt     = 1'b0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    data_err     = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_write    = 1'b0;
    mem_be       = '0;
    mem_wdata    = '0;
    if (!rst_sys) begin
      if (grant) begin
        if (win == OWN_DATA) data_gnt = 1'b1;
        else                 instr_gnt = 1'b1;
        if (in_range) begin
          mem_req  = 1'b1;
          mem_addr = win_addr;
          if (win == OWN_DATA) begin
            mem_write = data_we;
            mem_be    = data_be;
            mem_wdata = data_wdata;
          end
        end
      end
      if (resp_v) begin
        if (owner_q == OWN_DATA) begin
          data_rvalid = 1'b1;
          data_err    = resp_err;
          data_rdata  = resp_rdata;
        end else begin
          instr_rvalid = 1'b1;
          instr_err    = resp_err;
          instr_rdata  = resp_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tmo_cnt_d = tmo_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q == TMO_LAST) state_d = ST_ERR_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A grant overrides the completion path above.
    if (grant) begin
      state_d   = in_range ? ST_WAIT_MEM : ST_ERR_RESP;
      owner_d   = win;
      tmo_cnt_d = '0;
`ifdef MEM_ARB_RR_EN
      last_owner_d = win;
`endif
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_INSTR;
      tmo_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_DATA;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tmo_cnt_q <= tmo_cnt_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned MEM_SIZE  = 65536;
  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam int unsigned TIMEOUT   = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mrv;
    logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic        ignt;
    logic        irv;
    logic        ierr;
    logic [31:0] irdata;
    logic        dgnt;
    logic        drv;
    logic        derr;
    logic [31:0] drdata;
    logic        mreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] mwdata;
  } outs_t;

  typedef struct {
    in_t   i;
    outs_t o;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst_sys, instr_req, data_req, data_we, mem_rvalid;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic        mem_req, mem_write;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk_sys = ~clk_sys;

  mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .MEM_START(MEM_START), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one record for the transaction currently outstanding.
  bit          m_v, m_who, m_bad, m_last;
  int unsigned m_age;
  bit          n_v, n_who, n_bad, n_last;
  int unsigned n_age;
  outs_t       exp_m, act;

  task automatic chk_o(input string name, input outs_t a, input outs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic chk_n(input string name, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic model_eval(input in_t x);
    bit can_acc, rsp, rerr, w, ok;
    logic [31:0] a;
    exp_m = '0;
    n_v = m_v; n_who = m_who; n_bad = m_bad; n_age = m_age; n_last = m_last;
    if (x.rst) begin
      n_v = 1'b0; n_last = 1'b1; n_age = 0;
      return;
    end
    can_acc = 1'b0; rsp = 1'b0; rerr = 1'b0;
    if (!m_v) can_acc = 1'b1;
    else if (m_bad || m_age >= TIMEOUT) begin rsp = 1'b1; rerr = 1'b1; n_v = 1'b0; end
    else if (x.mrv) begin rsp = 1'b1; n_v = 1'b0; can_acc = 1'b1; end
    else n_age = m_age + 1;
    if (rsp) begin
      if (m_who) begin
        exp_m.drv = 1'b1; exp_m.derr = rerr; exp_m.drdata = rerr ? 32'h0 : x.mrdata;
      end else begin
        exp_m.irv = 1'b1; exp_m.ierr = rerr; exp_m.irdata = rerr ? 32'h0 : x.mrdata;
      end
    end
    if (can_acc && (x.ireq || x.dreq)) begin
      if (x.ireq && x.dreq) w = RR ? !m_last : 1'b0;
      else                  w = x.dreq;
      a  = w ? x.daddr : x.iaddr;
      ok = (64'(a) >= 64'(MEM_START)) && (64'(a) < 64'(MEM_START) + 64'(MEM_SIZE));
      if (w) exp_m.dgnt = 1'b1; else exp_m.ignt = 1'b1;
      if (ok) begin
        exp_m.mreq  = 1'b1;
        exp_m.maddr = a;
        if (w) begin exp_m.mwe = x.dwe; exp_m.mbe = x.dbe; exp_m.mwdata = x.dwdata; end
      end
      n_v = 1'b1; n_who = w; n_bad = !ok; n_age = 0; n_last = w;
    end
  endtask

  // Entered at posedge+1: drive, settle, compare against the model, clock.
  task automatic cycle(input in_t x);
    rst_sys = x.rst; instr_req = x.ireq; instr_addr = x.iaddr;
    data_req = x.dreq; data_we = x.dwe; data_be = x.dbe; data_addr = x.daddr;
    data_wdata = x.dwdata; mem_rvalid = x.mrv; mem_rdata = x.mrdata;
    #4;
    act.ignt = instr_gnt; act.irv = instr_rvalid; act.ierr = instr_err; act.irdata = instr_rdata;
    act.dgnt = data_gnt; act.drv = data_rvalid; act.derr = data_err; act.drdata = data_rdata;
    act.mreq = mem_req; act.maddr = mem_addr; act.mwe = mem_write; act.mbe = mem_be;
    act.mwdata = mem_wdata;
    model_eval(x);
    chk_o("model", act, exp_m);
    @(posedge clk_sys);
    #1;
    m_v = n_v; m_who = n_who; m_bad = n_bad; m_age = n_age; m_last = n_last;
  endtask

  function automatic in_t mk_in(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                                input bit dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input bit mrv, input logic [31:0] mrdata);
    in_t r;
    r.rst = 1'b0; r.ireq = ireq; r.iaddr = iaddr; r.dreq = dreq; r.dwe = dwe; r.dbe = dbe;
    r.daddr = daddr; r.dwdata = dwdata; r.mrv = mrv; r.mrdata = mrdata;
    return r;
  endfunction

  function automatic outs_t mk_out(input bit ignt, input bit irv, input bit ierr,
                                   input logic [31:0] irdata, input bit dgnt, input bit drv,
                                   input bit derr, input logic [31:0] drdata, input bit mreq,
                                   input logic [31:0] maddr, input bit mwe, input logic [3:0] mbe,
                                   input logic [31:0] mwdata);
    outs_t r;
    r.ignt = ignt; r.irv = irv; r.ierr = ierr; r.irdata = irdata;
    r.dgnt = dgnt; r.drv = drv; r.derr = derr; r.drdata = drdata;
    r.mreq = mreq; r.maddr = maddr; r.mwe = mwe; r.mbe = mbe; r.mwdata = mwdata;
    return r;
  endfunction

  function automatic in_t rst_in();
    in_t r;
    r = '0;
    r.rst = 1'b1;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[15];
    in_t   x;
    int    found, gnt_seen, silent;
    bit    wins[4];
    outs_t zero_o;
    zero_o = '0;

    tbl[0].i  = mk_in(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[0].o  = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 4'h0, 0);
    tbl[1].i  = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF);
    tbl[1].o  = mk_out(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tbl[2].i  = mk_in(0, 0, 1, 1, 4'b0011, 32'h20, 32'h1234ABCD, 0, 0);
    tbl[2].o  = mk_out(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 4'b0011, 32'h1234ABCD);
    tbl[3].i  = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h55);
    tbl[3].o  = mk_out(0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 4'h0, 0);
    tbl[4].i  = mk_in(0, 0, 1, 0, 4'hF, 32'h0001_0000, 0, 0, 0);
    tbl[4].o  = mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tbl[5].i  = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hFFFF);
    tbl[5].o  = mk_out(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'h0, 0);
    tbl[6].i  = mk_in(1, 32'h200, 1, 0, 4'hF, 32'h300, 0, 0, 0);
    tbl[6].o  = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 4'h0, 0);
    tbl[7].i  = mk_in(0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 32'h11);
    tbl[7].o  = mk_out(0, 1, 0, 32'h11, 1, 0, 0, 0, 1, 32'h300, 0, 4'hF, 0);
    tbl[8].i  = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h22);
    tbl[8].o  = mk_out(0, 0, 0, 0, 0, 1, 0, 32'h22, 0, 0, 0, 4'h0, 0);
    tbl[9].i  = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h33);
    tbl[9].o  = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tbl[10].i = mk_in(1, 32'h0002_0004, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[10].o = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tbl[11].i = mk_in(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[11].o = mk_out(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tbl[12].i = mk_in(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 0);
    tbl[12].o = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 4'h0, 0);
    tbl[13].i = mk_in(1, 32'h108, 0, 0, 4'h0, 0, 0, 1, 32'hCAFEF00D);
    tbl[13].o = mk_out(1, 1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 1, 32'h108, 0, 4'h0, 0);
    tbl[14].i = mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h0BADF00D);
    tbl[14].o = mk_out(0, 1, 0, 32'h0BADF00D, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);

    m_v = 0; m_who = 0; m_bad = 0; m_age = 0; m_last = 1;
    #1;
    cycle(rst_in());
    chk_o("reset_outputs", act, zero_o);
    cycle(rst_in());

    for (int k = 0; k < 15; k++) begin
      cycle(tbl[k].i);
      chk_o($sformatf("vec%0d", k), act, tbl[k].o);
    end

    // RAM never answers: error response appears in the ERR_RESP cycle,
    // TIMEOUT+1 cycles after the grant, with the data port blocked meanwhile.
    cycle(mk_in(1, 32'h40, 0, 0, 4'h0, 0, 0, 0, 0));
    chk_n("tmo_gnt", int'(act.ignt), 1);
    found = 0; gnt_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(mk_in(0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0));
      if (act.dgnt) gnt_seen++;
      if (act.irv) begin
        found = k;
        chk_n("tmo_err", int'(act.ierr), 1);
        break;
      end
    end
    chk_n("tmo_latency", found, TIMEOUT + 1);
    chk_n("tmo_no_gnt", gnt_seen, 0);
    cycle(mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h77));
    chk_o("late_rvalid", act, zero_o);

    // Reset in the middle of WAIT_MEM drops the transaction.
    cycle(mk_in(1, 32'h30, 0, 0, 4'h0, 0, 0, 0, 0));
    x = mk_in(1, 32'h34, 1, 1, 4'hF, 32'h38, 32'h99, 1, 32'h1234);
    x.rst = 1'b1;
    cycle(x);
    chk_o("rst_mid_wait", act, zero_o);
    cycle(rst_in());
    cycle(mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h5678));
    chk_o("no_stale_rvalid", act, zero_o);

    // Contention right after reset with a 1-cycle RAM for four accepts.
    cycle(rst_in());
    for (int k = 0; k < 4; k++) begin
      cycle(mk_in(1, 32'h10 + 32'(k), 1, 0, 4'hF, 32'h14, 0, (k != 0), 32'(k)));
      wins[k] = act.dgnt;
      chk_n($sformatf("arb_one_gnt%0d", k), int'(act.ignt) + int'(act.dgnt), 1);
    end
    chk_n("arb_order", int'({wins[0], wins[1], wins[2], wins[3]}), RR ? 4'b0101 : 4'b0000);
    cycle(mk_in(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hABCD));

    // Random traffic against the model, with occasional silent-RAM stretches and resets.
    silent = 0;
    for (int k = 0; k < 3000; k++) begin
      x.rst    = ($urandom_range(0, 199) == 0);
      x.ireq   = $urandom_range(0, 1);
      x.iaddr  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000) : {16'h0, 16'($urandom)};
      x.dreq   = $urandom_range(0, 1);
      x.dwe    = $urandom_range(0, 1);
      x.dbe    = 4'($urandom);
      x.daddr  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000) : {16'h0, 16'($urandom)};
      x.dwdata = $urandom;
      if (silent == 0 && $urandom_range(0, 39) == 0) silent = 25;
      if (silent > 0) begin
        silent--;
        x.mrv = 1'b0;
      end else begin
        x.mrv = ($urandom_range(0, 3) != 0);
      end
      x.mrdata = $urandom;
      cycle(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
